// File: rtl/des_key_sched.sv
// DES key schedule: expands a 64-bit key into the sixteen 48-bit round subkeys,
// in encrypt (K1..K16) or decrypt (K16..K1) order, one subkey per valid/ready transfer.
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic [47:0] subkey_out,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

    // FIPS 46-3 bit numbers (1 = MSB) selected by PC-1 (C half then D half) and PC-2.
    localparam logic [5:0] Pc1 [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50,
        6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
        6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54,
        6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
        6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };
    localparam logic [5:0] Pc2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,
        6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,
        6'd27, 6'd20, 6'd13, 6'd2,  6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };
    // Bit k set when shift SH[k+1] is 2 (schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
    localparam logic [15:0] ShTwo = 16'h7EFC;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [27:0] pc1_c, pc1_d;
    logic [55:0] cd;

    // PC-1 applied to the incoming key.
    always_comb begin
        pc1_c = '0;
        pc1_d = '0;
        for (int i = 0; i < 28; i++) begin
            pc1_c[27-i] = key_in[6'(7'd64 - {1'b0, Pc1[i]})];
            pc1_d[27-i] = key_in[6'(7'd64 - {1'b0, Pc1[28+i]})];
        end
    end

    // PC-2 applied to the live C,D registers; this is the subkey seen by the consumer.
    always_comb begin
        cd         = {c_q, d_q};
        subkey_out = '0;
        for (int i = 0; i < 48; i++) begin
            subkey_out[47-i] = cd[6'(6'd56 - Pc2[i])];
        end
    end

    // Next-state: load on start, advance the rotation on each accepted subkey.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Encrypt starts at K1 (one rotation); decrypt starts at K16 (net 28 = none).
                    c_d     = decrypt ? pc1_c : rotl(pc1_c, 1'b0);
                    d_d     = decrypt ? pc1_d : rotl(pc1_d, 1'b0);
                    cnt_d   = 4'd0;
                    mode_d  = decrypt;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (subkey_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (mode_q) begin
                            // SH[16-cnt] lives at bit 15-cnt.
                            c_d = rotr(c_q, ShTwo[~cnt_q]);
                            d_d = rotr(d_q, ShTwo[~cnt_q]);
                        end else begin
                            // SH[cnt+2] lives at bit cnt+1.
                            c_d = rotl(c_q, ShTwo[cnt_q + 4'd1]);
                            d_d = rotl(d_q, ShTwo[cnt_q + 4'd1]);
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign subkey_valid = (state_q == StEmit);
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign round_idx    = cnt_q;

endmodule

// File: tb/tb_des_key_sched.sv
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key_in = '0;
    logic        subkey_ready = 1'b0;
    logic [47:0] subkey_out;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] KeyA = 64'h133457799BBCDFF1;

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .subkey_out   (subkey_out),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference tables straight from FIPS 46-3.
    int pc1_t [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43,
                       35, 27, 19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54,
                       46, 38, 30, 22, 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    int pc2_t [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7,
                       27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39,
                       56, 34, 53, 46, 42, 50, 36, 29, 32};
    int sh_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Round subkey K_r (r = 1..16) computed from scratch with the cumulative shift.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        int cum;
        cum = 0;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = key[64-pc1_t[i]];
            d[27-i] = key[64-pc1_t[28+i]];
        end
        for (int j = 0; j < r; j++) cum += sh_t[j];
        cum = cum % 28;
        if (cum != 0) begin
            c = (c << cum) | (c >> (28 - cum));
            d = (d << cum) | (d >> (28 - cum));
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-pc2_t[i]];
        return k;
    endfunction

    // Behavioural model: phase 0 idle, 1 emitting, 2 done.
    int          m_phase = 0;
    int          m_idx = 0;
    logic        m_zero = 1'b1;
    logic [63:0] m_key = '0;
    logic        m_dec = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_idx   <= 0;
            m_zero  <= 1'b1;
            m_dec   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_idx   <= 0;
                    m_zero  <= 1'b0;
                    m_key   <= key_in;
                    m_dec   <= decrypt;
                end
                1: if (subkey_ready) begin
                    if (m_idx == 15) m_phase <= 2;
                    else m_idx <= m_idx + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [47:0] exp_sub;
        exp_sub = m_zero ? 48'h0 : ref_subkey(m_key, m_dec ? 16 - m_idx : m_idx + 1);
        tests++;
        if (subkey_out !== exp_sub || subkey_valid !== (m_phase == 1) ||
            busy !== (m_phase != 0) || done !== (m_phase == 2) ||
            round_idx !== 4'(m_idx)) begin
            fails++;
            $display("FAIL cycle t=%0t: got sub=%h v=%b busy=%b done=%b idx=%0d, want sub=%h v=%b busy=%b done=%b idx=%0d",
                     $time, subkey_out, subkey_valid, busy, done, round_idx, exp_sub,
                     m_phase == 1, m_phase != 0, m_phase == 2, m_idx);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic start_sched(input logic [63:0] key, input logic dec);
        start   = 1'b1;
        key_in  = key;
        decrypt = dec;
        cyc();
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = $urandom_range(1);
    endtask

    task automatic finish_sched(input int prob);
        int n;
        n = 0;
        while (m_phase != 0 && n < 200) begin
            subkey_ready = ($urandom_range(99) < prob);
            cyc();
            n++;
        end
        subkey_ready = 1'b0;
        check("finish_timeout", 64'(n >= 200), 64'd0);
    endtask

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        subkey_ready = 1'b1;
        while (!(m_phase == 1 && m_idx == target) && n < 40) begin
            cyc();
            n++;
        end
        subkey_ready = 1'b0;
        check("wait_idx_timeout", 64'(n >= 40), 64'd0);
    endtask

    initial begin
        int n;
        logic [47:0] held;

        // Pin the reference model with known FIPS vectors.
        check("model_k1", 64'(ref_subkey(KeyA, 1)), 64'h1B02EFFC7072);
        check("model_k2", 64'(ref_subkey(KeyA, 2)), 64'h79AED9DBC9E5);
        check("model_k16", 64'(ref_subkey(KeyA, 16)), 64'hCB3D8B0E17F5);

        repeat (3) cyc();
        check("reset_sub", 64'(subkey_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        cyc();

        // Encrypt with continuous ready; done visible 16 cycles after first subkey.
        start_sched(KeyA, 1'b0);
        check("enc_k1", 64'(subkey_out), 64'h1B02EFFC7072);
        check("enc_idx0", 64'(round_idx), 64'd0);
        subkey_ready = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            cyc();
            n++;
            if (n == 1) check("enc_k2", 64'(subkey_out), 64'h79AED9DBC9E5);
            if (n == 15) check("enc_k16", 64'(subkey_out), 64'hCB3D8B0E17F5);
        end
        check("enc_done_latency", 64'(n), 64'd16);
        cyc();
        subkey_ready = 1'b0;

        // Decrypt: reverse order.
        start_sched(KeyA, 1'b1);
        check("dec_k16_first", 64'(subkey_out), 64'hCB3D8B0E17F5);
        subkey_ready = 1'b1;
        repeat (15) cyc();
        check("dec_k1_last", 64'(subkey_out), 64'h1B02EFFC7072);
        check("dec_idx15", 64'(round_idx), 64'd15);
        finish_sched(100);

        // Backpressure at round 3.
        start_sched(KeyA, 1'b0);
        wait_idx(3);
        held = subkey_out;
        repeat (5) begin
            cyc();
            check("bp_stable_sub", 64'(subkey_out), 64'(held));
            check("bp_stable_idx", 64'(round_idx), 64'd3);
        end
        finish_sched(100);

        // Start ignored mid-schedule and during DONE.
        start_sched(KeyA, 1'b0);
        wait_idx(7);
        start = 1'b1; key_in = 64'h0123456789ABCDEF; decrypt = 1'b1;
        subkey_ready = 1'b1;
        cyc();
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_k9", 64'(subkey_out), 64'(ref_subkey(KeyA, 9)));
        n = 0;
        while (m_phase != 2 && n < 40) begin cyc(); n++; end
        check("ign_done_reached", 64'(done), 64'd1);
        start = 1'b1; key_in = 64'h0123456789ABCDEF;
        cyc();
        start = 1'b0;
        check("ign_done_start_busy", 64'(busy), 64'd0);
        check("ign_done_hold", 64'(subkey_out), 64'hCB3D8B0E17F5);
        cyc();

        // Asynchronous reset mid-schedule.
        start_sched(KeyA, 1'b0);
        wait_idx(9);
        rst = 1'b1;
        #1;
        check("rst_async_sub", 64'(subkey_out), 64'd0);
        check("rst_async_flags", 64'({subkey_valid, busy, done, round_idx}), 64'd0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        start_sched(KeyA, 1'b0);
        check("rst_restart_k1", 64'(subkey_out), 64'h1B02EFFC7072);
        finish_sched(100);

        // Random keys, modes and ready; back-to-back starts some of the time.
        for (int it = 0; it < 30; it++) begin
            start_sched({$urandom, $urandom}, 1'($urandom_range(1)));
            finish_sched($urandom_range(100, 30));
            repeat ($urandom_range(2)) cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: start  input  1  begin a key schedule; sampled only in IDLE.
REQ-004: decrypt  input  1  schedule direction: 0 = K1..K16 (encrypt), 1 = K16..K1 (decrypt); sampled with start.
REQ-005: key_in  input  64  DES key, FIPS 46-3 bit 1 = key_in[63]; parity bits ignored; sampled with start.
REQ-006: subkey_ready  input  1  consumer accepts the current subkey.
REQ-007: subkey_out  output  48  current round subkey, FIPS bit 1 = subkey_out[47]; 6-bit groups [47:42]..[5:0] feed S-boxes 1..8.
REQ-008: subkey_valid  output  1  subkey_out holds a valid subkey.
REQ-009: round_idx  output  4  issue index 0..15 of the current subkey.
REQ-010: busy  output  1  high in any state other than IDLE.
REQ-011: done  output  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-012: The block SHALL implement the FSM IDLE -> EMIT -> DONE -> IDLE.
REQ-013: Datapath registers SHALL be C[27:0], D[27:0], cnt[3:0] and a latched mode bit.
REQ-014: In IDLE with start=1, the block SHALL load C,D = PC-1(key_in) per FIPS 46-3, rotated left by 1 if decrypt=0 and unrotated if decrypt=1, clear cnt, latch decrypt, and enter EMIT.
REQ-015: Latency SHALL be exactly one cycle: start high at edge t gives subkey_valid=1 and round_idx=0 after edge t.
REQ-016: subkey_out SHALL equal PC-2(C,D) at all times; it is combinational from registers.
REQ-017: subkey_valid SHALL be 1 exactly in EMIT.
REQ-018: round_idx SHALL equal cnt.
REQ-019: Handshake: a transfer SHALL occur on a clock edge where subkey_valid=1 and subkey_ready=1.
REQ-020: Without a transfer, C, D and cnt SHALL hold, keeping subkey_out stable indefinitely.
REQ-021: Shift schedule SH[1..16] SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-022: On a transfer with cnt<15 in encrypt mode, C and D SHALL each rotate left by SH[cnt+2], and cnt SHALL increment.
REQ-023: On a transfer with cnt<15 in decrypt mode, C and D SHALL each rotate right by SH[16-cnt], and cnt SHALL increment.
REQ-024: On a transfer with cnt=15, the FSM SHALL enter DONE with no rotation.
REQ-025: DONE SHALL last exactly one cycle with done=1, subkey_valid=0 and busy=1, then return to IDLE.
REQ-026: C and D SHALL keep their last values after DONE until the next start or reset.
REQ-027: start outside IDLE SHALL be ignored, including in DONE; key_in and decrypt are not resampled.
REQ-028: subkey_ready outside EMIT SHALL be ignored.
REQ-029: Back-to-back operation: with subkey_ready held at 1, the 16 subkeys SHALL issue on 16 consecutive cycles.
REQ-030: A new start is accepted no earlier than the cycle after DONE, so back-to-back operation takes 18 cycles per key.
REQ-031: Over one full schedule, total rotation SHALL be 28 in either direction, so C,D in DONE for decrypt equal the PC-1 load value.

Reset
REQ-032: On rst=1, the block SHALL asynchronously force IDLE with C=0, D=0, cnt=0 and mode=0.
REQ-033: During reset, outputs SHALL be subkey_valid=0, busy=0, done=0, round_idx=0, subkey_out=0.
REQ-034: Reset during EMIT or DONE SHALL abort the schedule with no done pulse.
REQ-035: The first start after reset release SHALL behave per REQ-014.

Verification
REQ-036: Encrypt: key_in=133457799BBCDFF1, decrypt=0, subkey_ready=1 -> round_idx 0: 1B02EFFC7072; round_idx 1: 79AED9DBC9E5; round_idx 15: CB3D8B0E17F5; done pulses on cycle 17 after start.
REQ-037: Decrypt: same key, decrypt=1 -> round_idx 0: CB3D8B0E17F5; round_idx 15: 1B02EFFC7072; sequence is the exact reverse of REQ-036.
REQ-038: Backpressure: subkey_ready=0 for 5 cycles at round_idx 3 -> subkey_out and round_idx stable throughout; no skipped or repeated subkey afterwards.
REQ-039: Ignored inputs: start pulsed with a different key at round_idx 7 and during DONE -> schedule unaffected; busy stays 1.
REQ-040: Mid-operation reset: rst asserted at round_idx 9 -> all outputs 0 immediately; no done pulse; a new start with the REQ-036 key yields 1B02EFFC7072 first.
REQ-041: Random keys, random subkey_ready -> all 16 subkeys match a FIPS 46-3 reference model in both modes.
